sha256_nonce_sweeper: RTL and testbench

- Sequencer that drives the sha256_core byte bus (addr/data/we) and irq/readback to run a Bitcoin-mode nonce sweep without software in the loop.
- Software first preloads header bytes 0..75 into the core. The sweeper then, for each nonce, writes 4 nonce bytes, starts a double hash, waits for completion and checks the digest for a required count of trailing zero bytes.
- It stops on the first hit, on range exhaustion, on abort or on timeout.

---
 rtl/sha256_nonce_sweeper.sv | 229 ++++++++++++++++++++++
 tb/tb_sha256_nonce_sweeper.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sweeper.sv
// Nonce sweeper: drives the sha256_core byte bus through write-nonce / start / wait / digest-check
// loops until a hit, range exhaustion, abort or irq timeout.
module sha256_nonce_sweeper #(
    parameter logic [6:0]  NONCE_ADDR  = 7'd76,
    parameter logic [6:0]  STATUS_ADDR = 7'd80,
    parameter logic [6:0]  DIGEST_BASE = 7'd96,
    parameter logic [15:0] TIMEOUT     = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [31:0] i_nonce_first,
    input  logic [31:0] i_nonce_last,
    input  logic [5:0]  i_zero_bytes,
    output logic [6:0]  o_core_addr,
    output logic [7:0]  o_core_data,
    output logic        o_core_we,
    input  logic        i_core_irq,
    input  logic [7:0]  i_core_rdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_found,
    output logic        o_error,
    output logic [31:0] o_nonce,
    output logic [31:0] o_attempts
);

    typedef enum logic [3:0] {
        IDLE, WR_NONCE, GO, ARM, CLR, WAIT, READ, NEXT, STOP, FIN
    } state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [31:0] nonce, nonce_n;
    logic [31:0] last, last_n;
    logic [5:0]  zb, zb_n;
    logic        found, found_n;
    logic        error, error_n;
    logic [31:0] attempts, attempts_n;
    logic [31:0] nonce_out, nonce_out_n;
    logic        busy, busy_n;
    logic        done, done_n;
    logic [6:0]  core_addr, core_addr_n;
    logic [7:0]  core_data, core_data_n;
    logic        core_we, core_we_n;

    // Control protocol: i_start is a single-cycle request accepted only while o_busy is low;
    // o_busy stays high until the cycle o_done pulses, and results hold until the next accepted start.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        nonce_n     = nonce;
        last_n      = last;
        zb_n        = zb;
        found_n     = found;
        error_n     = error;
        attempts_n  = attempts;
        case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    nonce_n    = i_nonce_first;
                    last_n     = i_nonce_last;
                    zb_n       = (i_zero_bytes > 6'd32) ? 6'd32 : i_zero_bytes;
                    found_n    = 1'b0;
                    error_n    = 1'b0;
                    attempts_n = '0;
                    cnt_n      = '0;
                    state_n    = WR_NONCE;
                end
            end
            WR_NONCE: begin
                if (cnt[1:0] == 2'd3) begin
                    cnt_n   = '0;
                    state_n = GO;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            GO: begin
                cnt_n   = '0;
                state_n = ARM;
            end
            ARM: begin
                // irq dropping means the core has left INIT and latched the start request
                if (!i_core_irq) begin
                    state_n = CLR;
                end else if (cnt == TIMEOUT - 16'd1) begin
                    error_n = 1'b1;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            CLR: begin
                cnt_n   = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (i_core_irq) begin
                    attempts_n = (attempts == 32'hFFFF_FFFF) ? attempts : attempts + 32'd1;
                    cnt_n      = '0;
                    if (zb == 6'd0) begin
                        found_n = 1'b1;
                        state_n = STOP;
                    end else begin
                        state_n = READ;
                    end
                end else if (cnt == TIMEOUT - 16'd1) begin
                    error_n = 1'b1;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            READ: begin
                if (i_core_rdata != 8'd0) begin
                    state_n = NEXT;
                end else if (cnt[5:0] == zb - 6'd1) begin
                    found_n = 1'b1;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            NEXT: begin
                if (nonce == last) begin
                    state_n = STOP;
                end else begin
                    nonce_n = nonce + 32'd1;
                    cnt_n   = '0;
                    state_n = WR_NONCE;
                end
            end
            STOP:    state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Abort overrides whatever the sweep decided this cycle; STOP/FIN are already terminating
        if (i_abort && state != IDLE && state != STOP && state != FIN) begin
            state_n = STOP;
            found_n = 1'b0;
            error_n = 1'b0;
            nonce_n = nonce;
            cnt_n   = cnt;
        end

        busy_n      = (state_n != IDLE) && (state_n != FIN);
        done_n      = (state_n == FIN);
        nonce_out_n = (state_n == FIN) ? nonce : nonce_out;

        // Bus outputs are registered, so they are derived from the next state and counter
        core_addr_n = '0;
        core_data_n = '0;
        core_we_n   = 1'b0;
        case (state_n)
            WR_NONCE: begin
                core_addr_n = NONCE_ADDR + {5'd0, cnt_n[1:0]};
                core_data_n = nonce_n[{cnt_n[1:0], 3'b000} +: 8];
                core_we_n   = 1'b1;
            end
            GO: begin
                core_addr_n = STATUS_ADDR;
                core_data_n = 8'h03;
                core_we_n   = 1'b1;
            end
            CLR: begin
                core_addr_n = STATUS_ADDR;
                core_data_n = 8'h02;
                core_we_n   = 1'b1;
            end
            STOP: begin
                core_addr_n = STATUS_ADDR;
                core_data_n = 8'h00;
                core_we_n   = 1'b1;
            end
            READ: begin
                core_addr_n = DIGEST_BASE + 7'd31 - cnt_n[6:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nonce     <= '0;
            last      <= '0;
            zb        <= '0;
            found     <= 1'b0;
            error     <= 1'b0;
            attempts  <= '0;
            nonce_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            core_addr <= '0;
            core_data <= '0;
            core_we   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            nonce     <= nonce_n;
            last      <= last_n;
            zb        <= zb_n;
            found     <= found_n;
            error     <= error_n;
            attempts  <= attempts_n;
            nonce_out <= nonce_out_n;
            busy      <= busy_n;
            done      <= done_n;
            core_addr <= core_addr_n;
            core_data <= core_data_n;
            core_we   <= core_we_n;
        end
    end

    assign o_core_addr = core_addr;
    assign o_core_data = core_data;
    assign o_core_we   = core_we;
    assign o_busy      = busy;
    assign o_done      = done;
    assign o_found     = found;
    assign o_error     = error;
    assign o_nonce     = nonce_out;
    assign o_attempts  = attempts;

endmodule

// File: tb/tb_sha256_nonce_sweeper.sv
// Bench for sha256_nonce_sweeper: a behavioural core with a table-driven digest stands in for
// sha256_core; each task runs one scenario and compares against hand-derived values.
module tb_sha256_nonce_sweeper;

    localparam logic [31:0] HIT  = 32'h7C2B_AC1D;
    localparam logic [31:0] ALLZ = 32'h0000_0777;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nonce_first = '0;
    logic [31:0] nonce_last = '0;
    logic [5:0]  zero_bytes = '0;
    logic [6:0]  core_addr;
    logic [7:0]  core_data;
    logic        core_we;
    logic        core_irq;
    logic [7:0]  core_rdata;
    logic        busy, done, found, error;
    logic [31:0] nonce, attempts;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sha256_nonce_sweeper dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(start),
        .i_abort(abort),
        .i_nonce_first(nonce_first),
        .i_nonce_last(nonce_last),
        .i_zero_bytes(zero_bytes),
        .o_core_addr(core_addr),
        .o_core_data(core_data),
        .o_core_we(core_we),
        .i_core_irq(core_irq),
        .i_core_rdata(core_rdata),
        .o_busy(busy),
        .o_done(done),
        .o_found(found),
        .o_error(error),
        .o_nonce(nonce),
        .o_attempts(attempts)
    );

    // ---------------- core model ----------------
    logic [7:0]  mem [128];
    logic        core_busy;
    logic [5:0]  busy_cnt;
    logic        hang = 1'b0;
    logic [31:0] started_q[$];

    function automatic logic [7:0] dig_byte(input logic [31:0] n, input int i);
        if (n == ALLZ) return 8'h00;
        if (n == HIT) return (i >= 28) ? 8'h00 : 8'h5A;
        if (n == HIT - 32'd1) return (i >= 29) ? 8'h00 : 8'h11;
        return (i == 31) ? (n[7:0] | 8'h01) : 8'h33;
    endfunction

    assign core_rdata = mem[core_addr];

    always @(posedge clk) begin
        if (core_rst) begin
            core_busy <= 1'b0;
            core_irq  <= 1'b1;
            busy_cnt  <= '0;
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else begin
            if (core_we) mem[core_addr] <= core_data;
            if (core_busy) begin
                if (busy_cnt == 6'd0) begin
                    core_busy <= 1'b0;
                    core_irq  <= 1'b1;
                    for (int i = 0; i < 32; i++)
                        mem[96 + i] <= dig_byte({mem[79], mem[78], mem[77], mem[76]}, i);
                end else begin
                    busy_cnt <= busy_cnt - 6'd1;
                end
            end else if (core_we && core_addr == 7'd80 && core_data[0] && !hang) begin
                core_busy <= 1'b1;
                core_irq  <= 1'b0;
                busy_cnt  <= 6'd20;
                started_q.push_back({mem[79], mem[78], mem[77], mem[76]});
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [14:0] wr_q[$];
    logic [6:0]  rd_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (core_we) wr_q.push_back({core_addr, core_data});
        else if (core_addr >= 7'd96) rd_q.push_back(core_addr);
        if (done) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        wr_q.delete();
        rd_q.delete();
        started_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [31:0] f, input logic [31:0] l, input logic [5:0] z);
        nonce_first = f;
        nonce_last  = l;
        zero_bytes  = z;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit timed_out);
        cyc = 0;
        timed_out = 1'b0;
        while (!done) begin
            if (cyc >= 3000) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done); end
        checks++; if (core_we !== 1'b0 || core_addr !== 7'd0 || core_data !== 8'd0) begin errors++; $display("FAIL reset_bus we=%b addr=%0d data=%h expected 0", core_we, core_addr, core_data); end
        rst = 1'b0;
        core_rst = 1'b0;
        tick();
        checks++; if (found !== 1'b0 || error !== 1'b0 || nonce !== 32'd0 || attempts !== 32'd0) begin errors++; $display("FAIL reset_results found=%b error=%b nonce=%h attempts=%0d expected 0", found, error, nonce, attempts); end
    endtask

    task automatic test_single_hit;
        int cyc; bit to;
        logic [14:0] exp_wr[7];
        exp_wr = '{{7'd76, 8'h1D}, {7'd77, 8'hAC}, {7'd78, 8'h2B}, {7'd79, 8'h7C},
                   {7'd80, 8'h03}, {7'd80, 8'h02}, {7'd80, 8'h00}};
        clear_logs();
        pulse_start(HIT, HIT, 6'd4);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL single_done timed out after %0d cycles", cyc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done got %b expected 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %b expected 0", done); end
        repeat (5) tick();
        checks++; if (found !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL single_flags found=%b error=%b expected 1 0", found, error); end
        checks++; if (nonce !== HIT) begin errors++; $display("FAIL single_nonce got %h expected %h", nonce, HIT); end
        checks++; if (attempts !== 32'd1) begin errors++; $display("FAIL single_attempts got %0d expected 1", attempts); end
        checks++; if (wr_q.size() != 7) begin errors++; $display("FAIL single_wr_count got %0d expected 7", wr_q.size()); end
        for (int i = 0; i < 7 && i < wr_q.size(); i++) begin
            checks++; if (wr_q[i] !== exp_wr[i]) begin errors++; $display("FAIL single_wr[%0d] got %h expected %h", i, wr_q[i], exp_wr[i]); end
        end
        checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL single_rd_count got %0d expected 4", rd_q.size()); end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== 7'(127 - i)) begin errors++; $display("FAIL single_rd[%0d] got %0d expected %0d", i, rd_q[i], 127 - i); end
        end
    endtask

    task automatic test_multi_hit;
        int cyc; bit to;
        clear_logs();
        pulse_start(32'h7C2B_AC1A, 32'h7C2B_AC1F, 6'd4);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL multi_done timed out after %0d cycles", cyc); end
        repeat (5) tick();
        checks++; if (found !== 1'b1 || nonce !== HIT) begin errors++; $display("FAIL multi_result found=%b nonce=%h expected 1 %h", found, nonce, HIT); end
        checks++; if (attempts !== 32'd4) begin errors++; $display("FAIL multi_attempts got %0d expected 4", attempts); end
        checks++; if (started_q.size() != 4) begin errors++; $display("FAIL multi_starts got %0d expected 4", started_q.size()); end
        for (int i = 0; i < 4 && i < started_q.size(); i++) begin
            checks++; if (started_q[i] !== 32'h7C2B_AC1A + 32'(i)) begin errors++; $display("FAIL multi_order[%0d] got %h expected %h", i, started_q[i], 32'h7C2B_AC1A + 32'(i)); end
        end
        checks++; if (rd_q.size() != 10) begin errors++; $display("FAIL multi_rd_count got %0d expected 10", rd_q.size()); end
        checks++; if (wr_q.size() != 25) begin errors++; $display("FAIL multi_wr_count got %0d expected 25", wr_q.size()); end
        checks++; if (wr_q.size() == 0 || wr_q[wr_q.size() - 1] !== {7'd80, 8'h00}) begin errors++; $display("FAIL multi_last_wr got %h expected %h", (wr_q.size() == 0) ? 15'h0 : wr_q[wr_q.size() - 1], {7'd80, 8'h00}); end
        repeat (10) tick();
        checks++; if (wr_q.size() != 25) begin errors++; $display("FAIL multi_wr_after_stop got %0d expected 25", wr_q.size()); end
    endtask

    task automatic test_wrap;
        int cyc; bit to;
        logic [31:0] exp_n[4];
        exp_n = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        clear_logs();
        pulse_start(32'hFFFF_FFFE, 32'h0000_0001, 6'd32);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_done timed out after %0d cycles", cyc); end
        repeat (5) tick();
        checks++; if (found !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL wrap_flags found=%b error=%b expected 0 0", found, error); end
        checks++; if (nonce !== 32'd1) begin errors++; $display("FAIL wrap_nonce got %h expected 00000001", nonce); end
        checks++; if (attempts !== 32'd4) begin errors++; $display("FAIL wrap_attempts got %0d expected 4", attempts); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count got %0d expected 1", done_cnt); end
        checks++; if (started_q.size() != 4) begin errors++; $display("FAIL wrap_starts got %0d expected 4", started_q.size()); end
        for (int i = 0; i < 4 && i < started_q.size(); i++) begin
            checks++; if (started_q[i] !== exp_n[i]) begin errors++; $display("FAIL wrap_order[%0d] got %h expected %h", i, started_q[i], exp_n[i]); end
        end
    endtask

    task automatic test_zero_bytes;
        int cyc; bit to;
        clear_logs();
        pulse_start(32'd5, 32'd10, 6'd0);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL z0_done timed out after %0d cycles", cyc); end
        repeat (5) tick();
        checks++; if (found !== 1'b1 || nonce !== 32'd5 || attempts !== 32'd1) begin errors++; $display("FAIL z0_result found=%b nonce=%h attempts=%0d expected 1 5 1", found, nonce, attempts); end
        checks++; if (rd_q.size() != 0 || wr_q.size() != 7) begin errors++; $display("FAIL z0_bus reads=%0d writes=%0d expected 0 7", rd_q.size(), wr_q.size()); end

        clear_logs();
        pulse_start(ALLZ, ALLZ, 6'd40);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL z40_done timed out after %0d cycles", cyc); end
        repeat (5) tick();
        checks++; if (found !== 1'b1 || attempts !== 32'd1) begin errors++; $display("FAIL z40_result found=%b attempts=%0d expected 1 1", found, attempts); end
        checks++; if (rd_q.size() != 32) begin errors++; $display("FAIL z40_rd_count got %0d expected 32", rd_q.size()); end
        checks++; if (rd_q.size() != 32 || rd_q[31] !== 7'd96) begin errors++; $display("FAIL z40_last_rd got %0d expected 96", (rd_q.size() == 32) ? rd_q[31] : 7'd0); end
    endtask

    task automatic test_timeout;
        int cyc; bit to;
        clear_logs();
        hang = 1'b1;
        pulse_start(32'h0000_0040, 32'h0000_0050, 6'd4);
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL tmo_done timed out after %0d cycles", cyc); end
        checks++; if (cyc != 1030) begin errors++; $display("FAIL tmo_latency got %0d cycles expected 1030", cyc); end
        repeat (5) tick();
        hang = 1'b0;
        checks++; if (error !== 1'b1 || found !== 1'b0 || attempts !== 32'd0) begin errors++; $display("FAIL tmo_result error=%b found=%b attempts=%0d expected 1 0 0", error, found, attempts); end
        checks++; if (wr_q.size() != 6) begin errors++; $display("FAIL tmo_wr_count got %0d expected 6", wr_q.size()); end
        checks++; if (wr_q.size() == 0 || wr_q[wr_q.size() - 1] !== {7'd80, 8'h00}) begin errors++; $display("FAIL tmo_last_wr got %h expected %h", (wr_q.size() == 0) ? 15'h0 : wr_q[wr_q.size() - 1], {7'd80, 8'h00}); end
    endtask

    task automatic test_abort;
        int cyc; bit to; int w;
        clear_logs();
        pulse_start(32'h0000_0100, 32'h0000_01FF, 6'd4);
        w = 0;
        while (started_q.size() < 1 && w < 200) begin tick(); w++; end
        checks++; if (started_q.size() < 1) begin errors++; $display("FAIL abort_first_start got %0d starts expected 1", started_q.size()); end
        pulse_start(32'h0000_5000, 32'h0000_5000, 6'd0);
        w = 0;
        while (started_q.size() < 2 && w < 200) begin tick(); w++; end
        checks++; if (started_q.size() < 2) begin errors++; $display("FAIL abort_second_start got %0d starts expected 2", started_q.size()); end
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (core_we !== 1'b1 || core_addr !== 7'd80 || core_data !== 8'h00) begin errors++; $display("FAIL abort_stop_wr we=%b addr=%0d data=%h expected 1 80 00", core_we, core_addr, core_data); end
        wait_done(cyc, to);
        checks++; if (to) begin errors++; $display("FAIL abort_done timed out after %0d cycles", cyc); end
        repeat (5) tick();
        checks++; if (found !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL abort_flags found=%b error=%b expected 0 0", found, error); end
        checks++; if (attempts !== 32'd1) begin errors++; $display("FAIL abort_attempts got %0d expected 1", attempts); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_count got %0d expected 1", done_cnt); end
        checks++; if (started_q.size() != 2 || started_q[0] !== 32'h100 || started_q[1] !== 32'h101) begin errors++; $display("FAIL abort_nonces count=%0d expected 2 starts 100,101", started_q.size()); end
        repeat (30) tick();
    endtask

    task automatic test_idle_abort;
        clear_logs();
        nonce_first = 32'd1;
        nonce_last  = 32'd2;
        zero_bytes  = 6'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || wr_q.size() != 0) begin errors++; $display("FAIL idle_abort busy=%b writes=%0d expected 0 0", busy, wr_q.size()); end
    endtask

    task automatic test_mid_reset;
        clear_logs();
        pulse_start(32'h0000_0200, 32'h0000_02FF, 6'd4);
        repeat (2) tick();
        checks++; if (core_we !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre we=%b busy=%b expected 1 1", core_we, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (core_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_post we=%b busy=%b done=%b expected 0 0 0", core_we, busy, done); end
        repeat (10) tick();
        checks++; if (busy !== 1'b0 || started_q.size() != 0) begin errors++; $display("FAIL midrst_idle busy=%b starts=%0d expected 0 0", busy, started_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_wrap();
        test_zero_bytes();
        test_timeout();
        test_abort();
        test_idle_abort();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
